// File: rtl/lbist_ctrl_mc_if.sv
// ----------------------------------------------------------------------------
// lbist_ctrl_mc_if
// Purpose : bundles the test-access handshake and the TPG/ORA/FIL datapath
//           signals of the multi-channel LBIST controller.
// Modports: master - test-access side / datapath model (drives requests and
//                    datapath status, observes controller outputs)
//           slave  - the controller itself
// Signals : start, abort, stop_on_fail, pat_limit   request and run mode
//           TPG_END, ORA_RES, FIL_END               datapath status
//           BIST_RESET, TPG_RESET, FIL_INC          datapath control
//           busy, done, pass, aborted               run status
//           fail_map, pat_count, err_count          run results
// ----------------------------------------------------------------------------
interface lbist_ctrl_mc_if #(
   parameter int N_CH     = 4,
   parameter int ERR_BITS = 8,
   parameter int PAT_BITS = 16
);
   logic                     start;
   logic                     abort;
   logic                     stop_on_fail;
   logic [PAT_BITS-1:0]      pat_limit;
   logic                     TPG_END;
   logic [N_CH-1:0]          ORA_RES;
   logic                     FIL_END;
   logic                     BIST_RESET;
   logic                     TPG_RESET;
   logic                     FIL_INC;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic                     aborted;
   logic [N_CH-1:0]          fail_map;
   logic [PAT_BITS-1:0]      pat_count;
   logic [N_CH*ERR_BITS-1:0] err_count;

   modport master (
      output start, abort, stop_on_fail, pat_limit, TPG_END, ORA_RES, FIL_END,
      input  BIST_RESET, TPG_RESET, FIL_INC, busy, done, pass, aborted,
             fail_map, pat_count, err_count
   );

   modport slave (
      input  start, abort, stop_on_fail, pat_limit, TPG_END, ORA_RES, FIL_END,
      output BIST_RESET, TPG_RESET, FIL_INC, busy, done, pass, aborted,
             fail_map, pat_count, err_count
   );
endinterface

// File: rtl/lbist_ctrl_mc.sv
// ----------------------------------------------------------------------------
// lbist_ctrl_mc
// Purpose : multi-channel LBIST controller. Sequences the TPG, ORAs and fault
//           list through SETUP, RUN and DONE under a start/done handshake,
//           keeping saturating per-channel error counters, a sticky fail map
//           and a saturating pattern counter.
// Ports   : clk    - single rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - lbist_ctrl_mc_if slave modport (handshake, mode,
//                    datapath status in; datapath control and results out)
// ----------------------------------------------------------------------------
module lbist_ctrl_mc #(
   parameter int N_CH        = 4,
   parameter int ERR_BITS    = 8,
   parameter int PAT_BITS    = 16,
   parameter int SETUP_DELAY = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   lbist_ctrl_mc_if.slave bus
);
   localparam int SetW = (SETUP_DELAY > 1) ? $clog2(SETUP_DELAY) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_e;

   state_e              state_q,    state_d;
   logic [SetW-1:0]     setupCnt_q, setupCnt_d;
   logic [PAT_BITS-1:0] limit_q,    limit_d;
   logic [PAT_BITS-1:0] patCnt_q,   patCnt_d;
   logic [ERR_BITS-1:0] errCnt_q [N_CH];
   logic [ERR_BITS-1:0] errCnt_d [N_CH];
   logic [N_CH-1:0]     failMap_q,  failMap_d;
   logic                aborted_q,  aborted_d;

   logic                anyFail;
   logic [PAT_BITS:0]   patNext;
   logic                limitHit;

   assign anyFail  = |bus.ORA_RES;
   // One bit wider so the limit compare still works when pat_count is all-ones.
   assign patNext  = {1'b0, patCnt_q} + {{PAT_BITS{1'b0}}, 1'b1};
   assign limitHit = (limit_q != '0) && (patNext == {1'b0, limit_q});

   // State and result registers; everything clears asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         setupCnt_q <= '0;
         limit_q    <= '0;
         patCnt_q   <= '0;
         failMap_q  <= '0;
         aborted_q  <= 1'b0;
         for (int i = 0; i < N_CH; i++) errCnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         setupCnt_q <= setupCnt_d;
         limit_q    <= limit_d;
         patCnt_q   <= patCnt_d;
         failMap_q  <= failMap_d;
         aborted_q  <= aborted_d;
         for (int i = 0; i < N_CH; i++) errCnt_q[i] <= errCnt_d[i];
      end
   end

   // Next-state logic. A RUN cycle always books its pattern and errors before
   // the exit conditions are considered, so the last cycle is never lost.
   always_comb begin
      state_d    = state_q;
      setupCnt_d = setupCnt_q;
      limit_d    = limit_q;
      patCnt_d   = patCnt_q;
      failMap_d  = failMap_q;
      aborted_d  = aborted_q;
      for (int i = 0; i < N_CH; i++) errCnt_d[i] = errCnt_q[i];

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d    = SETUP;
               setupCnt_d = '0;
               limit_d    = bus.pat_limit;
               patCnt_d   = '0;
               failMap_d  = '0;
               aborted_d  = 1'b0;
               for (int i = 0; i < N_CH; i++) errCnt_d[i] = '0;
            end
         end
         SETUP: begin
            if (bus.abort) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end else if (setupCnt_q == SetW'(SETUP_DELAY - 1)) begin
               state_d = RUN;
            end else begin
               setupCnt_d = setupCnt_q + SetW'(1);
            end
         end
         RUN: begin
            if (patCnt_q != '1) patCnt_d = patNext[PAT_BITS-1:0];
            for (int i = 0; i < N_CH; i++) begin
               if (bus.ORA_RES[i]) begin
                  failMap_d[i] = 1'b1;
                  if (errCnt_q[i] != '1) errCnt_d[i] = errCnt_q[i] + ERR_BITS'(1);
               end
            end
            if (bus.abort) aborted_d = 1'b1;
            if (bus.abort || bus.FIL_END || (bus.stop_on_fail && anyFail) || limitHit)
               state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath control decodes straight from the state register; a failing
   // cycle restarts the TPG and steps the fault list.
   assign bus.BIST_RESET = (state_q != RUN);
   assign bus.TPG_RESET  = (state_q != RUN) | anyFail;
   assign bus.FIL_INC    = (state_q == RUN) & (anyFail | bus.TPG_END);

   assign bus.busy      = (state_q == SETUP) || (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = (state_q == DONE) && (failMap_q == '0) && !aborted_q;
   assign bus.aborted   = aborted_q;
   assign bus.fail_map  = failMap_q;
   assign bus.pat_count = patCnt_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_err
      assign bus.err_count[g*ERR_BITS +: ERR_BITS] = errCnt_q[g];
   end
endmodule

// File: tb/tb_lbist_ctrl_mc.sv
// ----------------------------------------------------------------------------
// tb_lbist_ctrl_mc
// Purpose : self-checking bench for lbist_ctrl_mc. Each run is described as a
//           per-RUN-cycle stimulus table; the expected run length and results
//           are worked out from that table before the run is driven.
// ----------------------------------------------------------------------------
module tb_lbist_ctrl_mc;
   localparam int N_CH        = 4;
   localparam int ERR_BITS    = 8;
   localparam int PAT_BITS    = 16;
   localparam int SETUP_DELAY = 3;
   localparam int MAXC        = 320;
   localparam int ERR_MAX     = (1 << ERR_BITS) - 1;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [N_CH-1:0] stOra   [MAXC];
   bit              stFil   [MAXC];
   bit              stAbort [MAXC];
   bit              stTpg   [MAXC];

   lbist_ctrl_mc_if #(.N_CH(N_CH), .ERR_BITS(ERR_BITS), .PAT_BITS(PAT_BITS)) bus ();

   lbist_ctrl_mc #(
      .N_CH(N_CH), .ERR_BITS(ERR_BITS), .PAT_BITS(PAT_BITS), .SETUP_DELAY(SETUP_DELAY)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a run never reaches the summary.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check is counted here.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".BIST_RESET"}, 64'(bus.BIST_RESET), 64'd1);
      checkOutput({tag, ".TPG_RESET"},  64'(bus.TPG_RESET),  64'd1);
      checkOutput({tag, ".FIL_INC"},    64'(bus.FIL_INC),    64'd0);
      checkOutput({tag, ".busy"},       64'(bus.busy),       64'd0);
      checkOutput({tag, ".done"},       64'(bus.done),       64'd0);
      checkOutput({tag, ".pass"},       64'(bus.pass),       64'd0);
      checkOutput({tag, ".aborted"},    64'(bus.aborted),    64'd0);
      checkOutput({tag, ".fail_map"},   64'(bus.fail_map),   64'd0);
      checkOutput({tag, ".pat_count"},  64'(bus.pat_count),  64'd0);
      checkOutput({tag, ".err_count"},  64'(bus.err_count),  64'd0);
   endtask

   task automatic clearStim();
      for (int c = 0; c < MAXC; c++) begin
         stOra[c]   = '0;
         stFil[c]   = 1'b0;
         stAbort[c] = 1'b0;
         stTpg[c]   = 1'b0;
      end
      stFil[MAXC-1] = 1'b1;
   endtask

   task automatic idleInputs();
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.ORA_RES      = '0;
      bus.FIL_END      = 1'b0;
      bus.TPG_END      = 1'b0;
   endtask

   // Starts a run from IDLE/DONE, plays the stimulus table and checks the
   // per-cycle controls and the final results against the table's outcome.
   task automatic applyStimulus(input string tag, input int limit, input bit sof, input int abortSetup);
      int              runLen;
      bit              expAborted;
      int              errs [N_CH];
      logic [N_CH-1:0] expMap;
      bit              expPass;

      // Expected outcome: first RUN cycle meeting an exit rule ends the run.
      runLen     = 0;
      expAborted = (abortSetup != 0);
      if (abortSetup == 0) begin
         for (int c = 0; c < MAXC; c++) begin
            runLen = c + 1;
            if (stAbort[c]) expAborted = 1'b1;
            if (stAbort[c] || stFil[c] || (sof && stOra[c] != 0) ||
                (limit != 0 && c + 1 == limit)) break;
         end
      end
      expMap = '0;
      for (int i = 0; i < N_CH; i++) begin
         errs[i] = 0;
         for (int c = 0; c < runLen; c++) if (stOra[c][i]) errs[i]++;
         if (errs[i] > ERR_MAX) errs[i] = ERR_MAX;
         if (errs[i] != 0) expMap[i] = 1'b1;
      end
      expPass = (expMap == 0) && !expAborted;

      // Start edge.
      bus.start        = 1'b1;
      bus.abort        = 1'b0;
      bus.pat_limit    = PAT_BITS'(limit);
      bus.stop_on_fail = sof;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.pat_limit = PAT_BITS'($urandom);

      // SETUP: datapath held in reset, ORA/FIL activity ignored.
      for (int s = 1; s <= SETUP_DELAY; s++) begin
         bus.abort   = (s == abortSetup);
         bus.ORA_RES = N_CH'($urandom);
         bus.FIL_END = 1'($urandom);
         bus.TPG_END = 1'($urandom);
         @(negedge clk);
         checkOutput({tag, ".setup.busy"},       64'(bus.busy),       64'd1);
         checkOutput({tag, ".setup.BIST_RESET"}, 64'(bus.BIST_RESET), 64'd1);
         checkOutput({tag, ".setup.TPG_RESET"},  64'(bus.TPG_RESET),  64'd1);
         checkOutput({tag, ".setup.FIL_INC"},    64'(bus.FIL_INC),    64'd0);
         @(posedge clk); #1;
         if (s == abortSetup) break;
      end
      idleInputs();

      // RUN: one table row per cycle; start and pat_limit wiggle harmlessly.
      for (int c = 0; c < runLen; c++) begin
         bus.ORA_RES   = stOra[c];
         bus.FIL_END   = stFil[c];
         bus.abort     = stAbort[c];
         bus.TPG_END   = stTpg[c];
         bus.start     = ($urandom_range(0, 3) == 0);
         bus.pat_limit = PAT_BITS'($urandom);
         @(negedge clk);
         if (c == 0 || c == runLen - 1 || stOra[c] != 0 || ($urandom_range(0, 7) == 0)) begin
            checkOutput({tag, ".run.BIST_RESET"}, 64'(bus.BIST_RESET), 64'd0);
            checkOutput({tag, ".run.TPG_RESET"},  64'(bus.TPG_RESET),  64'(stOra[c] != 0));
            checkOutput({tag, ".run.FIL_INC"},    64'(bus.FIL_INC),    64'((stOra[c] != 0) || stTpg[c]));
            checkOutput({tag, ".run.busy"},       64'(bus.busy),       64'd1);
         end
         @(posedge clk); #1;
      end
      idleInputs();

      // First DONE cycle: registered results.
      @(negedge clk);
      checkOutput({tag, ".done"},       64'(bus.done),       64'd1);
      checkOutput({tag, ".busy"},       64'(bus.busy),       64'd0);
      checkOutput({tag, ".BIST_RESET"}, 64'(bus.BIST_RESET), 64'd1);
      checkOutput({tag, ".pass"},       64'(bus.pass),       64'(expPass));
      checkOutput({tag, ".aborted"},    64'(bus.aborted),    64'(expAborted));
      checkOutput({tag, ".pat_count"},  64'(bus.pat_count),  64'(runLen));
      checkOutput({tag, ".fail_map"},   64'(bus.fail_map),   64'(expMap));
      for (int i = 0; i < N_CH; i++)
         checkOutput($sformatf("%s.err%0d", tag, i),
                     64'(bus.err_count[i*ERR_BITS +: ERR_BITS]), 64'(errs[i]));

      // DONE holds: abort and datapath status have no effect.
      @(posedge clk); #1;
      bus.abort   = 1'b1;
      bus.ORA_RES = '1;
      bus.FIL_END = 1'b1;
      @(negedge clk);
      checkOutput({tag, ".hold.FIL_INC"}, 64'(bus.FIL_INC), 64'd0);
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      checkOutput({tag, ".hold.done"},      64'(bus.done),      64'd1);
      checkOutput({tag, ".hold.aborted"},   64'(bus.aborted),   64'(expAborted));
      checkOutput({tag, ".hold.pat_count"}, 64'(bus.pat_count), 64'(runLen));
      checkOutput({tag, ".hold.fail_map"},  64'(bus.fail_map),  64'(expMap));
      @(posedge clk); #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.pat_limit    = '0;
      bus.stop_on_fail = 1'b0;
      idleInputs();

      // Reset values before any clock edge.
      #3;
      checkResetValues("por");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Clean run of five patterns.
      clearStim();
      applyStimulus("clean5", 5, 1'b0, 0);

      // Two failing cycles on channels 0 and 2 (RUN cycles 2 and 7).
      clearStim();
      stOra[1] = 4'b0101;
      stOra[6] = 4'b0101;
      applyStimulus("fail0101", 10, 1'b0, 0);

      // Stop on first failure, channel 3 on RUN cycle 4.
      clearStim();
      stOra[3] = 4'b1000;
      applyStimulus("sof", 0, 1'b1, 0);

      // Same with a coincident fault-list end.
      clearStim();
      stOra[3] = 4'b1000;
      stFil[3] = 1'b1;
      applyStimulus("sofFil", 0, 1'b1, 0);

      // Channel 1 failing every cycle long enough to saturate.
      clearStim();
      for (int c = 0; c < 300; c++) stOra[c] = 4'b0010;
      applyStimulus("saturate", 300, 1'b0, 0);

      // Abort in the second SETUP cycle, then a normal run.
      clearStim();
      applyStimulus("abortSetup", 5, 1'b0, 2);
      clearStim();
      applyStimulus("afterAbort", 4, 1'b0, 0);

      // Randomized runs.
      for (int t = 0; t < 8; t++) begin
         int lim;
         clearStim();
         lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
         for (int c = 0; c < MAXC - 1; c++) begin
            stOra[c]   = ($urandom_range(0, 4) == 0) ? N_CH'($urandom) : '0;
            stFil[c]   = ($urandom_range(0, 29) == 0);
            stAbort[c] = ($urandom_range(0, 39) == 0);
            stTpg[c]   = 1'($urandom);
         end
         applyStimulus($sformatf("rand%0d", t), lim, 1'($urandom),
                       ($urandom_range(0, 5) == 0) ? $urandom_range(1, SETUP_DELAY) : 0);
      end

      // Reset pulsed mid-RUN with errors already counted.
      bus.start        = 1'b1;
      bus.pat_limit    = '0;
      bus.stop_on_fail = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (SETUP_DELAY + 3) begin
         bus.ORA_RES = '1;
         @(posedge clk); #1;
      end
      checkOutput("midrun.preReset.busy", 64'(bus.busy), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetValues("midrun");
      bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("midrunHeld");
      idleInputs();
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("midrun.release.busy", 64'(bus.busy), 64'd0);
      checkOutput("midrun.release.done", 64'(bus.done), 64'd0);
      @(posedge clk); #1;

      clearStim();
      applyStimulus("afterReset", 6, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
